// File: rtl/spi_flash_reader.sv
// spi_flash_reader: streams bytes from an SPI flash (READ command) through a
// Wishbone-attached SPI master core, one byte in flight at a time.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o read request handshake (ready only when idle)
//   req_addr_i [23:0]       flash byte address
//   req_len_i  [7:0]        byte count, 0 means 256
//   data_o [7:0]            received flash byte
//   data_valid_o            data_o valid, held until data_ready_i
//   data_ready_i            sink accepts data_o
//   busy_o                  transaction in progress
//   done_o                  one-cycle pulse at end of transaction
//   m_cyc_o/m_stb_o         Wishbone cycle/strobe (always equal)
//   m_we_o, m_adr_o [2:0]   Wishbone write enable, SPI register address
//   m_dat_o [7:0]           Wishbone write data
//   m_dat_i [7:0], m_ack_i  Wishbone read data, acknowledge
module spi_flash_reader #(
   parameter int unsigned CS_INDEX  = 0,
   parameter logic [7:0]  SPCR_VAL  = 8'h50,
   parameter logic [7:0]  SPER_VAL  = 8'h00,
   parameter logic [7:0]  RD_OPCODE = 8'h03
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [23:0] req_addr_i,
   input  logic [7:0]  req_len_i,
   output logic [7:0]  data_o,
   output logic        data_valid_o,
   input  logic        data_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   output logic        m_we_o,
   output logic [2:0]  m_adr_o,
   output logic [7:0]  m_dat_o,
   input  logic [7:0]  m_dat_i,
   input  logic        m_ack_i
);
   typedef enum logic [3:0] {
      IDLE, CFG_SPCR, CFG_SPER, CS_ON, TX, POLL, RX, OUT, CS_OFF, DONE
   } state_t;
   localparam logic [7:0] CS_MASK = 8'd1 << CS_INDEX;
   localparam logic [2:0] A_SPCR = 3'd0;
   localparam logic [2:0] A_SPSR = 3'd1;
   localparam logic [2:0] A_SPDR = 3'd2;
   localparam logic [2:0] A_SPER = 3'd3;
   localparam logic [2:0] A_CS   = 3'd4;
   state_t      state, state_n;
   logic        gap;
   logic [23:0] addr;
   logic [8:0]  remaining;
   logic [2:0]  hdr;
   logic [7:0]  rx;
   logic        ack;
   logic [7:0]  tx_byte;
   // gap is set for the cycle right after every acknowledge, which forces the
   // mandatory idle bus cycle between accesses without extra states
   assign m_cyc_o      = !(state inside {IDLE, OUT, DONE}) && !gap;
   assign m_stb_o      = m_cyc_o;
   assign ack          = m_cyc_o && m_ack_i;
   assign req_ready_o  = state == IDLE;
   assign busy_o       = state != IDLE;
   assign done_o       = state == DONE;
   assign data_valid_o = state == OUT;
   assign data_o       = rx;
   // hdr counts header bytes already exchanged; hdr[2] marks the data phase
   assign tx_byte = hdr == 3'd0 ? RD_OPCODE :
                    hdr == 3'd1 ? addr[23:16] :
                    hdr == 3'd2 ? addr[15:8] :
                    hdr == 3'd3 ? addr[7:0] : 8'h00;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         gap       <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         hdr       <= '0;
         rx        <= '0;
      end else begin
         state <= state_n;
         gap   <= ack;
         if (state == IDLE && req_valid_i) begin
            addr      <= req_addr_i;
            remaining <= req_len_i == 8'd0 ? 9'd256 : {1'b0, req_len_i};
            hdr       <= '0;
         end
         if (state == RX && ack) begin
            rx <= m_dat_i;
            if (!hdr[2]) hdr <= hdr + 3'd1;
         end
         if (state == OUT && data_ready_i) remaining <= remaining - 9'd1;
      end
   end
   always_comb begin
      state_n = state;
      m_we_o  = 1'b0;
      m_adr_o = '0;
      m_dat_o = '0;
      case (state)
         IDLE: state_n = req_valid_i ? CFG_SPCR : IDLE;
         CFG_SPCR: begin
            m_we_o  = 1'b1;
            m_adr_o = A_SPCR;
            m_dat_o = SPCR_VAL;
            state_n = ack ? CFG_SPER : CFG_SPCR;
         end
         CFG_SPER: begin
            m_we_o  = 1'b1;
            m_adr_o = A_SPER;
            m_dat_o = SPER_VAL;
            state_n = ack ? CS_ON : CFG_SPER;
         end
         CS_ON: begin
            m_we_o  = 1'b1;
            m_adr_o = A_CS;
            m_dat_o = CS_MASK;
            state_n = ack ? TX : CS_ON;
         end
         TX: begin
            m_we_o  = 1'b1;
            m_adr_o = A_SPDR;
            m_dat_o = tx_byte;
            state_n = ack ? POLL : TX;
         end
         // bit0 of SPSR is rfempty: keep polling until the received byte lands
         POLL: begin
            m_adr_o = A_SPSR;
            state_n = ack && !m_dat_i[0] ? RX : POLL;
         end
         RX: begin
            m_adr_o = A_SPDR;
            state_n = !ack ? RX : hdr[2] ? OUT : TX;
         end
         OUT: state_n = !data_ready_i ? OUT : remaining == 9'd1 ? CS_OFF : TX;
         CS_OFF: begin
            m_we_o  = 1'b1;
            m_adr_o = A_CS;
            state_n = ack ? DONE : CS_OFF;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench with an SPI-core/flash slave model and a
// per-cycle compare process for the spi_flash_reader.
module tb_spi_flash_reader;
   logic        clk = 1'b0;
   logic        rst_i, req_valid_i, req_ready_o, data_valid_o, data_ready_i;
   logic        busy_o, done_o, m_cyc_o, m_stb_o, m_we_o, m_ack_i;
   logic [23:0] req_addr_i;
   logic [7:0]  req_len_i, data_o, m_dat_o, m_dat_i;
   logic [2:0]  m_adr_o;
   always #5 clk = ~clk;
   spi_flash_reader dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i), .data_o(data_o),
      .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .busy_o(busy_o),
      .done_o(done_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
   );
   int checks = 0, passed = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask
   // flash contents as a pure function of the byte address
   function automatic logic [7:0] flash(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction
   int ack_delay = 0, empty_polls = 0, stall_at = -1, stall_len = 0;
   logic [10:0] exp_wr[$];
   logic [7:0]  exp_data[$];
   bit          in_txn, cs_act, pending, prev_wait, held_v, next_access, expect_resume;
   int          hs_cnt, wr_cnt, polls_last, stall_cnt, exp_total, wcnt, fidx, pcnt;
   int          cyc_no, done_cyc, accept_cyc;
   logic [7:0]  last_data, resp, held;
   logic [23:0] faddr;
   logic [11:0] prev_bus;
   task automatic slave_access();
      logic [2:0]  a;
      logic [7:0]  d;
      logic [10:0] e;
      a = m_adr_o;
      d = m_dat_o;
      next_access = 1'b1;
      m_dat_i = 8'h00;
      if (m_we_o) begin
         wr_cnt++;
         e = exp_wr.size() != 0 ? exp_wr.pop_front() : 11'h7FF;
         check("bus_write", {a, d}, e);
         if (a == 3'd4) begin
            cs_act = d != 8'h00;
            fidx = 0;
            if (d == 8'h00) next_access = 1'b0;
         end
         if (a == 3'd2) begin
            check("one_outstanding", pending, 0);
            pending = 1'b1;
            if (fidx >= 1 && fidx <= 3) faddr = {faddr[15:0], d};
            resp = fidx < 4 ? 8'hFF : flash(faddr + 24'(fidx - 4));
            fidx++;
         end
      end else begin
         check("read_addr_valid", a == 3'd1 || a == 3'd2, 1);
         if (a == 3'd1) begin
            m_dat_i = pcnt < empty_polls ? 8'h05 : 8'h04;
            pcnt++;
         end else if (a == 3'd2) begin
            check("rx_after_tx", pending, 1);
            check("polls_before_rx", pcnt, empty_polls + 1);
            polls_last = pcnt;
            pcnt = 0;
            pending = 1'b0;
            m_dat_i = resp;
            if (fidx > 4) next_access = 1'b0;
         end
      end
   endtask
   // slave + compare process: everything sampled and driven at negedge
   initial begin
      m_ack_i = 1'b0;
      m_dat_i = 8'h00;
      data_ready_i = 1'b1;
      forever begin
         @(negedge clk);
         cyc_no++;
         if (rst_i) begin
            m_ack_i = 1'b0;
            exp_wr.delete();
            exp_data.delete();
            in_txn = 0; cs_act = 0; pending = 0; prev_wait = 0; held_v = 0;
            expect_resume = 0; wcnt = 0; pcnt = 0; stall_cnt = 0; fidx = 0;
            data_ready_i = 1'b1;
         end else begin
            check("stb_eq_cyc", m_stb_o, m_cyc_o);
            check("busy", busy_o, in_txn);
            check("req_ready", req_ready_o, !in_txn);
            if (m_ack_i) begin
               m_ack_i = 1'b0;
               check("gap_after_ack", m_cyc_o, 0);
               expect_resume = next_access;
            end else begin
               if (expect_resume) begin
                  check("resume_after_gap", m_cyc_o, 1);
                  expect_resume = 1'b0;
               end
               if (prev_wait) check("cyc_held_until_ack", m_cyc_o, 1);
               if (m_cyc_o) begin
                  if (prev_wait) check("bus_stable", {m_adr_o, m_we_o, m_dat_o}, prev_bus);
                  if (wcnt == ack_delay) begin
                     m_ack_i = 1'b1;
                     prev_wait = 1'b0;
                     wcnt = 0;
                     slave_access();
                  end else begin
                     wcnt++;
                     prev_wait = 1'b1;
                     prev_bus = {m_adr_o, m_we_o, m_dat_o};
                  end
               end
            end
            if (data_valid_o) begin
               check("no_valid_in_header", fidx > 4, 1);
               check("no_bus_while_out", m_cyc_o, 0);
               if (held_v) check("data_stable", data_o, held);
               held = data_o;
               held_v = 1'b1;
               data_ready_i = !(hs_cnt == stall_at && stall_cnt < stall_len);
               if (!data_ready_i) stall_cnt++;
               else begin
                  if (exp_data.size() == 0) check("data_count", hs_cnt + 1, exp_total);
                  else check("data_byte", data_o, exp_data.pop_front());
                  last_data = data_o;
                  hs_cnt++;
                  held_v = 1'b0;
                  stall_cnt = 0;
               end
            end else begin
               held_v = 1'b0;
               data_ready_i = 1'b1;
            end
            if (done_o) begin
               check("done_in_txn", in_txn, 1);
               check("done_all_data", exp_data.size(), 0);
               check("done_all_writes", exp_wr.size(), 0);
               check("cs_released", cs_act, 0);
               in_txn = 1'b0;
               done_cyc = cyc_no;
            end
            if (req_valid_i && req_ready_o) begin
               in_txn = 1'b1;
               accept_cyc = cyc_no;
               hs_cnt = 0;
               wr_cnt = 0;
               exp_total = req_len_i == 8'd0 ? 256 : int'(req_len_i);
               exp_wr.push_back({3'd0, 8'h50});
               exp_wr.push_back({3'd3, 8'h00});
               exp_wr.push_back({3'd4, 8'h01});
               exp_wr.push_back({3'd2, 8'h03});
               exp_wr.push_back({3'd2, req_addr_i[23:16]});
               exp_wr.push_back({3'd2, req_addr_i[15:8]});
               exp_wr.push_back({3'd2, req_addr_i[7:0]});
               for (int i = 0; i < exp_total; i++) begin
                  exp_wr.push_back({3'd2, 8'h00});
                  exp_data.push_back(flash(req_addr_i + 24'(i)));
               end
               exp_wr.push_back({3'd4, 8'h00});
            end
         end
      end
   end
   task automatic start(input logic [23:0] a, input logic [7:0] l);
      @(posedge clk); #1;
      req_addr_i = a;
      req_len_i = l;
      req_valid_i = 1'b1;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask
   task automatic wait_done(input int limit, input string name);
      int n = 0;
      while (!done_o && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_done"}, done_o, 1);
      @(posedge clk); #1;
   endtask
   initial begin
      int d1;
      bit seen;
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      req_addr_i = '0;
      req_len_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cyc", m_cyc_o, 0);
      check("rst_we", m_we_o, 0);
      check("rst_adr", m_adr_o, 0);
      check("rst_dat", m_dat_o, 0);
      check("rst_valid", data_valid_o, 0);
      check("rst_done", done_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ready", req_ready_o, 1);
      rst_i = 1'b0;
      // basic single-byte read
      start(24'h123456, 8'd1);
      wait_done(500, "t1");
      check("t1_bytes", hs_cnt, 1);
      check("t1_byte_val", last_data, 8'h2A);
      check("t1_writes", wr_cnt, 9);
      check("t1_polls", polls_last, 1);
      // slow slave and busy receive FIFO
      ack_delay = 5;
      empty_polls = 3;
      start(24'hABCDEF, 8'd2);
      wait_done(2000, "t2");
      check("t2_polls", polls_last, 4);
      check("t2_bytes", hs_cnt, 2);
      check("t2_last", last_data, 8'hCC);
      // sink back-pressure on byte 2 of 4
      ack_delay = 0;
      empty_polls = 1;
      stall_at = 1;
      stall_len = 20;
      start(24'h00FFFE, 8'd4);
      wait_done(1000, "t3");
      check("t3_bytes", hs_cnt, 4);
      check("t3_last", last_data, 8'h5A);
      stall_at = -1;
      // len 0 means 256 bytes, address wraps past 24'hFFFFFF
      empty_polls = 0;
      start(24'hFFFF80, 8'd0);
      wait_done(5000, "t4");
      check("t4_bytes", hs_cnt, 256);
      check("t4_last", last_data, 8'h25);
      // reset in the middle of a TX access
      start(24'h000010, 8'd3);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk); #1;
         seen = m_cyc_o && m_we_o && m_adr_o == 3'd2;
      end
      check("t5_tx_seen", seen, 1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      check("t5_cyc", m_cyc_o, 0);
      check("t5_ready", req_ready_o, 1);
      check("t5_busy", busy_o, 0);
      rst_i = 1'b0;
      start(24'h000020, 8'd2);
      wait_done(500, "t5");
      check("t5_bytes", hs_cnt, 2);
      // request held high across a whole transaction
      @(posedge clk); #1;
      req_addr_i = 24'h000100;
      req_len_i = 8'd2;
      req_valid_i = 1'b1;
      wait_done(500, "t6a");
      d1 = done_cyc;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      check("t6_accept_after_done", accept_cyc, d1 + 1);
      wait_done(500, "t6b");
      check("t6_bytes", hs_cnt, 2);
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CS_INDEX, default 0: bit set in the CS register (addr 4) to select the flash; range 0..7.
REQ-002 SHALL have parameter SPCR_VAL, default 8'h50: value written to SPCR (addr 0); enable, master, mode 0, interrupt off.
REQ-003 SHALL have parameter SPER_VAL, default 8'h00: value written to SPER (addr 3).
REQ-004 SHALL have parameter RD_OPCODE, default 8'h03: command byte sent first.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  read request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  24  flash byte address.
- req_len_i  in  8  byte count; 0 means 256.
- data_o  out  8  received flash byte.
- data_valid_o  out  1  data_o valid.
- data_ready_i  in  1  sink accepts data_o.
- busy_o  out  1  high from request accept until done_o.
- done_o  out  1  one-cycle pulse at end of transaction.
- m_cyc_o  out  1  Wishbone cycle.
- m_stb_o  out  1  Wishbone strobe, always equal to m_cyc_o.
- m_we_o  out  1  Wishbone write enable.
- m_adr_o  out  3  SPI register address.
- m_dat_o  out  8  write data.
- m_dat_i  in  8  read data.
- m_ack_i  in  1  Wishbone acknowledge.

Function
REQ-006 req_ready_o SHALL be high only in IDLE; on accept, latch addr, remaining = (len==0 ? 256 : len) in a 9-bit counter, and header index 0.
REQ-007 Bus access: assert cyc/stb with stable adr/we/dat until the cycle m_ack_i=1, then drop cyc/stb for exactly one cycle before any further access; capture m_dat_i in the ack cycle.
REQ-008 States and accesses, in order:
- CFG_SPCR: write SPCR_VAL to addr 0.
- CFG_SPER: write SPER_VAL to addr 3.
- CS_ON: write (1<<CS_INDEX) to addr 4.
- TX: write a byte to addr 2.
- POLL: read addr 1.
- RX: read addr 2.
- OUT: present the received byte.
- CS_OFF: write 0 to addr 4.
- DONE.
REQ-009 TX byte SHALL be RD_OPCODE, addr[23:16], addr[15:8], addr[7:0] for header indexes 0..3, then 8'h00 for every data byte.
REQ-010 POLL SHALL repeat (with the one-cycle gap) while captured bit0 (rfempty)=1, and go to RX when 0; no timeout.
REQ-011 After RX of a header byte: discard, increment header index, return to TX; after the 4th header byte's RX, the next TX sends the first dummy byte.
REQ-012 After RX of a data byte: go to OUT, drive data_valid_o=1 with the byte, hold data_o stable until data_ready_i=1, then decrement remaining; if remaining becomes 0 go to CS_OFF, else TX.
REQ-013 data_valid_o SHALL never assert during the header phase; exactly req_len bytes (256 for 0) are emitted, in flash order.
REQ-014 DONE SHALL pulse done_o for one cycle and return to IDLE; busy_o falls in that same DONE cycle boundary (low in IDLE).
REQ-015 req_valid_i SHALL be ignored while busy; a request present in the IDLE cycle following DONE is accepted.
REQ-016 Only one byte SHALL be outstanding in the SPI FIFOs at any time, so FIFO overrun (wcol) never occurs.

Reset
REQ-017 On rst_i (any state, including mid-access): state IDLE, cyc/stb/we low, adr/dat 0, data_valid_o 0, done_o 0, busy_o 0, req_ready_o 1 from the first cycle after reset; the shared rst_i resets the SPI master, releasing CS.

Verification
REQ-018 Reset then req addr 24'h123456 len 1 -> bus writes 50@0, 00@3, 01@4, 03/12/34/56/00@2 interleaved with polls, one data_valid with the slave byte, write 00@4, done_o pulse.
REQ-019 len 0 -> exactly 256 data_valid handshakes, then CS_OFF write and done_o.
REQ-020 data_ready_i held low 20 cycles at byte 2 of len 4 -> data_o stable, no bus activity, and then bytes 3-4 complete normally.
REQ-021 Slave ack delayed 5 cycles and rfempty=1 for 3 polls -> cyc/stb held until ack, one idle cycle between accesses, and 4 polls issued before RX.
REQ-022 rst_i asserted during a TX access -> next cycle cyc/stb 0, IDLE, req_ready_o 1; a new request then completes correctly.
REQ-023 req_valid_i held high through the transaction -> second request accepted only in the cycle after done_o.
